// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings {CS#,RAS#,CAS#,WE#},
// arbiter state encoding and the idle bank/address pattern.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP      = 4'b0111;
  localparam logic [3:0] CMD_PRE      = 4'b0010;
  localparam logic [3:0] CMD_ACT      = 4'b0011;
  localparam logic [3:0] CMD_WR       = 4'b0100;
  localparam logic [3:0] CMD_RD       = 4'b0101;
  localparam logic [3:0] CMD_AREF     = 4'b0001;
  localparam logic [3:0] CMD_BST_STOP = 4'b0110;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

  // Idle bank/address lines are all ones; truncate to the pin width at use.
  localparam logic [31:0] IDLE_ALL = 32'hFFFF_FFFF;

endpackage

// File: rtl/sdram_arb_grant.sv
// Picks the next bus owner from pending requests while the arbiter is idle.
// Refresh always wins; with SDRAM_ARB_RR_EN write and read alternate.
module sdram_arb_grant
  import sdram_pkg::*;
(
`ifdef SDRAM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arbit,
`endif
  input  logic       aref_req,
  input  logic       wr_req,
  input  logic       rd_req,
  output arb_state_t pick
);

`ifdef SDRAM_ARB_RR_EN
  logic last_wr;

  // Remember which of write/read was served last so the other goes next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr <= 1'b0;
    end else if (arbit) begin
      if (pick == ST_WRITE) begin
        last_wr <= 1'b1;
      end else if (pick == ST_READ) begin
        last_wr <= 1'b0;
      end
    end
  end

  always_comb begin
    pick = ST_ARBIT;
    if (aref_req) begin
      pick = ST_AREF;
    end else if (wr_req && !(rd_req && last_wr)) begin
      pick = ST_WRITE;
    end else if (rd_req) begin
      pick = ST_READ;
    end
  end
`else
  always_comb begin
    pick = ST_ARBIT;
    if (aref_req) begin
      pick = ST_AREF;
    end else if (wr_req) begin
      pick = ST_WRITE;
    end else if (rd_req) begin
      pick = ST_READ;
    end
  end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM pin set between init, refresh, write and read engines.
// Define SDRAM_ARB_RR_EN for write/read round-robin instead of write-first.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int DQ_W = 16,
  parameter int BA_W = 2,
  parameter int A_W  = 13
) (
  input  logic            arb_clk,
  input  logic            arb_rst_n,
  input  logic            init_end,
  input  logic [3:0]      init_cmd,
  input  logic [BA_W-1:0] init_bank,
  input  logic [A_W-1:0]  init_addr,
  input  logic            aref_req,
  input  logic            aref_end,
  input  logic [3:0]      aref_cmd,
  input  logic [BA_W-1:0] aref_bank,
  input  logic [A_W-1:0]  aref_addr,
  input  logic            wr_req,
  input  logic            wr_end,
  input  logic [3:0]      wr_cmd,
  input  logic [BA_W-1:0] wr_bank,
  input  logic [A_W-1:0]  wr_addr,
  input  logic            wr_sdram_en,
  input  logic [DQ_W-1:0] wr_sdram_data,
  input  logic            rd_req,
  input  logic            rd_end,
  input  logic [3:0]      rd_cmd,
  input  logic [BA_W-1:0] rd_bank,
  input  logic [A_W-1:0]  rd_addr,
  output logic            aref_en,
  output logic            wr_en,
  output logic            rd_en,
  output logic [DQ_W-1:0] rd_sdram_data,
  output logic            sdram_cke,
  output logic            sdram_cs_n,
  output logic            sdram_ras_n,
  output logic            sdram_cas_n,
  output logic            sdram_we_n,
  output logic [BA_W-1:0] sdram_ba,
  output logic [A_W-1:0]  sdram_addr,
  inout  wire  [DQ_W-1:0] sdram_dq
);

  arb_state_t      state;
  arb_state_t      next_state;
  arb_state_t      pick;
  logic [3:0]      cmd;
  logic            dq_oe;

  sdram_arb_grant u_grant (
`ifdef SDRAM_ARB_RR_EN
    .clk      (arb_clk),
    .rst_n    (arb_rst_n),
    .arbit    (state == ST_ARBIT),
`endif
    .aref_req (aref_req),
    .wr_req   (wr_req),
    .rd_req   (rd_req),
    .pick     (pick)
  );

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= next_state;
    end
  end

  // Only the granted engine's end pulse releases the bus; no pre-emption.
  always_comb begin
    next_state = state;
    case (state)
      ST_INIT:  if (init_end) next_state = ST_ARBIT;
      ST_ARBIT: next_state = pick;
      ST_AREF:  if (aref_end) next_state = ST_ARBIT;
      ST_WRITE: if (wr_end)   next_state = ST_ARBIT;
      ST_READ:  if (rd_end)   next_state = ST_ARBIT;
      default:  next_state = ST_INIT;
    endcase
  end

  always_comb begin
    cmd        = CMD_NOP;
    sdram_ba   = BA_W'(IDLE_ALL);
    sdram_addr = A_W'(IDLE_ALL);
    aref_en    = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    dq_oe      = 1'b0;
    case (state)
      ST_INIT: begin
        cmd        = init_cmd;
        sdram_ba   = init_bank;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        cmd        = aref_cmd;
        sdram_ba   = aref_bank;
        sdram_addr = aref_addr;
        aref_en    = 1'b1;
      end
      ST_WRITE: begin
        cmd        = wr_cmd;
        sdram_ba   = wr_bank;
        sdram_addr = wr_addr;
        wr_en      = 1'b1;
        dq_oe      = wr_sdram_en;
      end
      ST_READ: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_bank;
        sdram_addr = rd_addr;
        rd_en      = 1'b1;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke     = 1'b1;
  assign sdram_dq      = dq_oe ? wr_sdram_data : {DQ_W{1'bz}};
  assign rd_sdram_data = sdram_dq;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: table of per-cycle request vectors plus
// hand sequences for DQ tristate, async reset mid-grant and write/read order.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int E_INIT = 0, E_ARBIT = 1, E_AREF = 2, E_WRITE = 3, E_READ = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic [3:0]  init_cmd;
  logic [1:0]  init_bank;
  logic [12:0] init_addr;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;
  logic        aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] rd_sdram_data;
  wire  [15:0] sdram_dq;
  logic        tb_dq_en;
  logic [15:0] tb_dq;

  localparam logic [3:0]  AREF_CMD = CMD_AREF;
  localparam logic [1:0]  AREF_BA  = 2'b10;
  localparam logic [12:0] AREF_A   = 13'h0AAA;
  localparam logic [3:0]  WR_CMD   = CMD_PRE;
  localparam logic [1:0]  WR_BA    = 2'b01;
  localparam logic [12:0] WR_A     = 13'h0400;
  localparam logic [3:0]  RD_CMD   = CMD_RD;
  localparam logic [1:0]  RD_BA    = 2'b00;
  localparam logic [12:0] RD_A     = 13'h0123;

  assign sdram_dq = tb_dq_en ? tb_dq : 16'hzzzz;

  sdram_arbiter dut (
    .arb_clk(clk), .arb_rst_n(rst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(AREF_CMD), .aref_bank(AREF_BA), .aref_addr(AREF_A),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_cmd(WR_CMD), .wr_bank(WR_BA), .wr_addr(WR_A),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_cmd(RD_CMD), .rd_bank(RD_BA), .rd_addr(RD_A),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .rd_sdram_data(rd_sdram_data), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
  );

  always #5 clk = ~clk;

  wire [21:0] act = {aref_en, wr_en, rd_en, sdram_cs_n, sdram_ras_n,
                     sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr};

  typedef struct {
    logic ie, ar, ae, wq, we, rq, re;
    int   exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(logic ie, logic ar, logic ae, logic wq,
                              logic we, logic rq, logic re, int e);
    vec_t v;
    v.ie = ie; v.ar = ar; v.ae = ae; v.wq = wq;
    v.we = we; v.rq = rq; v.re = re; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic logic [21:0] model(int s);
    case (s)
      E_INIT:  return {3'b000, init_cmd, init_bank, init_addr};
      E_AREF:  return {3'b100, AREF_CMD, AREF_BA, AREF_A};
      E_WRITE: return {3'b010, WR_CMD, WR_BA, WR_A};
      E_READ:  return {3'b001, RD_CMD, RD_BA, RD_A};
      default: return {3'b000, 4'b0111, 2'b11, 13'h1fff};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  int rr_exp[4];
  int got;

  initial begin
    // Columns: init_end aref_req aref_end wr_req wr_end rd_req rd_end -> state
    for (int i = 0; i < 9; i++) add(0, 0, 0, 0, 0, 0, 0, E_INIT);
    add(1, 0, 0, 0, 0, 0, 0, E_ARBIT);
    add(1, 0, 0, 0, 0, 0, 0, E_ARBIT);
    add(1, 1, 0, 1, 0, 1, 0, E_AREF);
    add(1, 1, 0, 1, 0, 1, 0, E_AREF);
    add(1, 0, 1, 1, 0, 1, 0, E_ARBIT);
    add(1, 0, 0, 1, 0, 1, 0, E_WRITE);
    add(1, 0, 0, 1, 0, 1, 1, E_WRITE);
    add(1, 0, 1, 1, 0, 1, 0, E_WRITE);
    add(1, 0, 0, 0, 1, 1, 0, E_ARBIT);
    add(1, 0, 0, 0, 0, 1, 0, E_READ);
    add(1, 0, 0, 0, 0, 0, 1, E_ARBIT);
    add(1, 0, 0, 1, 0, 0, 0, E_WRITE);
    add(1, 1, 0, 0, 0, 0, 0, E_WRITE);
    add(1, 1, 0, 0, 1, 0, 0, E_ARBIT);
    add(1, 1, 0, 0, 0, 0, 0, E_AREF);
    add(1, 0, 1, 0, 0, 0, 0, E_ARBIT);
    add(1, 0, 0, 0, 0, 0, 0, E_ARBIT);

`ifdef SDRAM_ARB_RR_EN
    rr_exp = '{1, 2, 1, 2};
`else
    rr_exp = '{1, 1, 1, 1};
`endif

    rst_n = 1'b0;
    {init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end} = '0;
    init_cmd = CMD_ACT; init_bank = 2'b01; init_addr = 13'h0555;
    wr_sdram_en = 1'b0; wr_sdram_data = 16'h0000;
    tb_dq_en = 1'b0; tb_dq = 16'h0000;

    #12;
    chk("reset_pins", {10'd0, act}, {10'd0, model(E_INIT)});
    chk("reset_cke", {31'd0, sdram_cke}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      {init_end, aref_req, aref_end} = {vecs[i].ie, vecs[i].ar, vecs[i].ae};
      {wr_req, wr_end, rd_req, rd_end} = {vecs[i].wq, vecs[i].we, vecs[i].rq, vecs[i].re};
      init_cmd  = (i % 2 == 1) ? CMD_PRE : CMD_AREF;
      init_bank = 2'(i);
      init_addr = 13'(i * 37 + 1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), {10'd0, act}, {10'd0, model(vecs[i].exp)});
    end

    // DQ drive in WRITE, release otherwise
    @(negedge clk);
    {aref_req, aref_end, rd_req, rd_end} = '0;
    wr_req = 1'b1; wr_sdram_en = 1'b1; wr_sdram_data = 16'hA5C3;
    @(posedge clk); #1;
    chk("dq_write_grant", {10'd0, act}, {10'd0, model(E_WRITE)});
    chk("dq_drive", {16'd0, sdram_dq}, 32'h0000A5C3);
    chk("dq_readback", {16'd0, rd_sdram_data}, 32'h0000A5C3);
    @(negedge clk);
    wr_req = 1'b0; wr_sdram_en = 1'b0; tb_dq = 16'h3C5A; tb_dq_en = 1'b1;
    #1 chk("dq_wr_en_low", {16'd0, rd_sdram_data}, 32'h00003C5A);
    @(negedge clk);
    tb_dq_en = 1'b0; wr_end = 1'b1;
    @(posedge clk); #1;
    chk("wr_release", {10'd0, act}, {10'd0, model(E_ARBIT)});
    @(negedge clk);
    wr_end = 1'b0; wr_sdram_en = 1'b1; tb_dq = 16'h1234; tb_dq_en = 1'b1;
    #1 chk("dq_arbit_released", {16'd0, rd_sdram_data}, 32'h00001234);

    // Asynchronous reset while READ is granted
    @(negedge clk);
    rd_req = 1'b1;
    @(posedge clk); #1;
    chk("read_grant", {10'd0, act}, {10'd0, model(E_READ)});
    chk("dq_read_released", {16'd0, rd_sdram_data}, 32'h00001234);
    #2 rst_n = 1'b0; tb_dq = 16'hBEEF;
    #1;
    chk("rst_async_pins", {10'd0, act}, {10'd0, model(E_INIT)});
    chk("rst_dq_released", {16'd0, rd_sdram_data}, 32'h0000BEEF);
    @(negedge clk);
    rd_req = 1'b0; tb_dq_en = 1'b0; wr_sdram_en = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reinit_arbit", {10'd0, act}, {10'd0, model(E_ARBIT)});

    // Write/read ordering with both requests held
    @(negedge clk);
    wr_req = 1'b1; rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      got = 0;
      for (int t = 0; t < 8 && got == 0; t++) begin
        @(posedge clk); #1;
        if (wr_en) got = 1;
        else if (rd_en) got = 2;
      end
      chk($sformatf("order_grant%0d", g), got, rr_exp[g]);
      @(negedge clk);
      wr_end = (got == 1);
      rd_end = (got == 2);
      @(posedge clk); #1;
      chk($sformatf("order_nop%0d", g), {10'd0, act}, {10'd0, model(E_ARBIT)});
      @(negedge clk);
      wr_end = 1'b0; rd_end = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Owns the single SDRAM command/address/data pin set and shares it between the four controller engines: init, auto-refresh, write and read. Holds the bus for the init engine until `init_end`, then arbitrates requests, grants one engine at a time and multiplexes that engine's command, bank, address and DQ drive onto the device pins. Sits between the engines and the SDRAM pad boundary at the top of the control path.

## Interface
Parameters:
- `DQ_W`, 16, SDRAM data width.
- `BA_W`, 2, bank address width.
- `A_W`, 13, row/column address width.

Ports:
- `arb_clk`  in  1  controller clock; all logic on rising edge.
- `arb_rst_n`  in  1  asynchronous, active-low reset.
- `init_end`  in  1  level; init sequence complete.
- `init_cmd`/`init_bank`/`init_addr`  in  4/BA_W/A_W  init engine bus.
- `aref_req`  in  1  refresh request; level, held until granted.
- `aref_end`  in  1  refresh done pulse.
- `aref_cmd`/`aref_bank`/`aref_addr`  in  4/BA_W/A_W  refresh engine bus.
- `wr_req`  in  1  write request; level.
- `wr_end`  in  1  write done pulse.
- `wr_cmd`/`wr_bank`/`wr_addr`  in  4/BA_W/A_W  write engine bus.
- `wr_sdram_en`  in  1  write engine DQ drive enable.
- `wr_sdram_data`  in  DQ_W  write data.
- `rd_req`  in  1  read request; level.
- `rd_end`  in  1  read done pulse.
- `rd_cmd`/`rd_bank`/`rd_addr`  in  4/BA_W/A_W  read engine bus.
- `aref_en`/`wr_en`/`rd_en`  out  1  grants to the engines.
- `rd_sdram_data`  out  DQ_W  DQ pins returned to the read engine.
- `sdram_cke`  out  1  clock enable; constant 1.
- `sdram_cs_n`/`sdram_ras_n`/`sdram_cas_n`/`sdram_we_n`  out  1  command pins.
- `sdram_ba`  out  BA_W  bank pins.
- `sdram_addr`  out  A_W  address pins.
- `sdram_dq`  inout  DQ_W  data pins.

## Operation
- Engine commands use the encoding {CS#, RAS#, CAS#, WE#}. NOP is 4'b0111.
- The FSM has five states: INIT, ARBIT, AREF, WRITE, READ. The state register is one-hot or binary, encoded per the package.
- INIT:
  - Pins follow the `init_*` bus.
  - Goes to ARBIT on the first edge with `init_end`=1.
- ARBIT:
  - Pins are NOP, `sdram_ba`=all ones, `sdram_addr`=all ones.
  - Priority is `aref_req` > `wr_req` > `rd_req`; the selected request moves the FSM to AREF, WRITE or READ.
  - With no request, stays in ARBIT.
- AREF / WRITE / READ:
  - Pins follow the granted engine's bus.
  - The matching `*_en` output is 1 throughout the state.
  - The matching `*_end` returns the FSM to ARBIT.
- No pre-emption. A request arriving during another grant waits; requests are sampled only in ARBIT.
- `*_end` pulses from non-granted engines are ignored.
- `sdram_dq` is driven with `wr_sdram_data` only when state is WRITE and `wr_sdram_en`=1; otherwise it is high-Z.
- `rd_sdram_data` = `sdram_dq` continuously.
- In WRITE, `sdram_addr[10]` is passed through unmodified, so the precharge command 13'h0400 reaches the pins intact.

## Timing
- Reset: state=INIT; `aref_en`=`wr_en`=`rd_en`=0; `sdram_cke`=1; `sdram_dq` high-Z; pins mirror the `init_*` bus.
- Grant latency: request seen in ARBIT at edge N → `*_en`=1 from edge N (registered state). The engine's first command appears on the pins combinationally from its own registers.
- Release: `*_end` high at edge M → state=ARBIT and `*_en`=0 after edge M. The engine's END→IDLE transition therefore never sees `*_en` high again.
- ARBIT occupies at least one cycle between back-to-back grants, so the bus carries NOP for at least one cycle.
- Pin mux, `*_en` decode and DQ tristate are combinational from state. There is no extra output register stage.
- Asynchronous reset mid-grant returns to INIT immediately. The engines are reset by the same net.

## Configuration
- `SDRAM_ARB_RR_EN` defined:
  - Write and read alternate when both are pending in ARBIT. A 1-bit `last_wr` register (reset 0) is set on a WRITE grant and cleared on a READ grant; the engine not served last wins.
  - Refresh still has absolute priority.
- Undefined: fixed write > read priority, and no `last_wr` register exists.

## Structure
- Shared package `sdram_pkg`:
  - Command constants: CMD_NOP, CMD_PRE, CMD_ACT, CMD_WR, CMD_RD, CMD_AREF, CMD_BST_STOP.
  - Arbiter state encoding.
  - Idle bank/address constants (all ones).
- Sub-module `sdram_arb_grant`: combinational pick of the next state from the three requests, plus `last_wr` under the macro.
- Pin mux and DQ tristate stay in the top module.

## Test plan
- Reset, then `init_end` rises at cycle 10 → INIT held until then with pins tracking the `init_*` bus; ARBIT one cycle later with pins 4'b0111 / 2'b11 / 13'h1fff.
- `aref_req`, `wr_req` and `rd_req` all high in ARBIT → `aref_en`=1 first; after `aref_end`, `wr_en`; after `wr_end`, `rd_en`. There is one NOP cycle between each grant.
- `wr_req` granted, `aref_req` rises mid-burst → `wr_en` stays 1 until `wr_end`; `aref_en`=1 one ARBIT cycle later.
- WRITE with `wr_sdram_en`=1 and `wr_sdram_data`=16'hA5C3 → `sdram_dq`=16'hA5C3. With `wr_sdram_en`=0, and in every non-WRITE state, `sdram_dq` is Z.
- With `SDRAM_ARB_RR_EN`, `wr_req` and `rd_req` held high for 4 grants → order W, R, W, R. Without the macro the order is W, W, W, W.
- `arb_rst_n` asserted during READ → `rd_en`=0 asynchronously, state INIT, DQ released.
